// File: rtl/mux_scan_2ch.sv
// Two-channel W-bit N:1 multiplexer with direct-select and dwell-timed auto-scan modes.
// Each channel is an identical, independent slice; only clk, rst_n, mode and dwell are
// shared. All outputs are registered.
module mux_scan_2ch #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*N*W-1:0]  din,
  input  logic [SW-1:0]     sel1,
  input  logic [SW-1:0]     sel2,
  input  logic              e1,
  input  logic              e2,
  input  logic              mode,
  input  logic [7:0]        dwell,
  output logic [W-1:0]      y1,
  output logic [W-1:0]      y2,
  output logic              v1,
  output logic              v2,
  output logic [SW-1:0]     idx1,
  output logic [SW-1:0]     idx2,
  output logic              wrap1,
  output logic              wrap2
);

  logic [W-1:0]  din_a [2][N];
  logic [SW-1:0] sel_a [2];
  logic [1:0]    en;
  logic          scan_q;
  logic          entry;
  logic [7:0]    lim;

  for (genvar c = 0; c < 2; c++) begin : g_din_c
    for (genvar k = 0; k < N; k++) begin : g_din_k
      assign din_a[c][k] = din[(c*N+k)*W +: W];
    end
  end

  assign sel_a[0] = sel1;
  assign sel_a[1] = sel2;
  assign en       = {e2, e1};

  // Mode seen at the previous edge. Resets to 1 so that scanning straight out of reset
  // starts from index 0 instead of being treated as a direct->scan entry.
  always_ff @(posedge clk) begin
    if (!rst_n) scan_q <= 1'b1;
    else        scan_q <= mode;
  end

  assign entry = mode & ~scan_q;
  // Last counter value of a dwell period; dwell of 0 behaves like 1.
  assign lim   = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [SW-1:0] ptr_q, ptr_d, cur, idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d, cnt_cur;
    logic [W-1:0]  y_q, y_d;
    logic          v_q, v_d, wrap_q, wrap_d, pend_q, pend_d;

    // On scan entry the index loads the select and the counter starts from zero.
    assign cur     = entry ? sel_a[c] : ptr_q;
    assign cnt_cur = entry ? 8'd0 : cnt_q;

    // Next-state: output data, scan index, dwell counter and wrap bookkeeping.
    always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      pend_d = pend_q;
      y_d    = '0;
      v_d    = 1'b0;
      wrap_d = 1'b0;
      if (en[c]) begin
        v_d = 1'b1;
        if (!mode) begin
          y_d    = din_a[c][sel_a[c]];
          idx_d  = sel_a[c];
          ptr_d  = sel_a[c];
          cnt_d  = 8'd0;
          pend_d = 1'b0;
        end else begin
          y_d    = din_a[c][cur];
          idx_d  = cur;
          // A wrap step seen last edge is flagged on the cycle index 0 is presented.
          wrap_d = pend_q;
          pend_d = 1'b0;
          if (cnt_cur >= lim) begin
            cnt_d  = 8'd0;
            ptr_d  = cur + SW'(1);
            pend_d = (cur == SW'(N-1));
          end else begin
            cnt_d = cnt_cur + 8'd1;
            ptr_d = cur;
          end
        end
      end
    end

    // Channel state and output registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ptr_q  <= '0;
        cnt_q  <= 8'd0;
        idx_q  <= '0;
        pend_q <= 1'b0;
        y_q    <= '0;
        v_q    <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        ptr_q  <= ptr_d;
        cnt_q  <= cnt_d;
        idx_q  <= idx_d;
        pend_q <= pend_d;
        y_q    <= y_d;
        v_q    <= v_d;
        wrap_q <= wrap_d;
      end
    end
  end

  assign y1    = g_ch[0].y_q;
  assign v1    = g_ch[0].v_q;
  assign idx1  = g_ch[0].idx_q;
  assign wrap1 = g_ch[0].wrap_q;
  assign y2    = g_ch[1].y_q;
  assign v2    = g_ch[1].v_q;
  assign idx2  = g_ch[1].idx_q;
  assign wrap2 = g_ch[1].wrap_q;

endmodule

// File: tb/tb_mux_scan_2ch.sv
// Directed bench for mux_scan_2ch (W=8, N=4). The driver pushes the expected outputs
// for each edge into a queue; a negedge monitor pops and compares them.
module tb_mux_scan_2ch;

  localparam int W = 8;
  localparam int N = 4;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2*N*W-1:0] din;
  logic [SW-1:0]    sel1, sel2;
  logic             e1, e2, mode;
  logic [7:0]       dwell;
  logic [W-1:0]     y1, y2;
  logic             v1, v2, wrap1, wrap2;
  logic [SW-1:0]    idx1, idx2;

  mux_scan_2ch #(.W(W), .N(N), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel1(sel1), .sel2(sel2), .e1(e1), .e2(e2),
    .mode(mode), .dwell(dwell), .y1(y1), .y2(y2), .v1(v1), .v2(v2), .idx1(idx1),
    .idx2(idx2), .wrap1(wrap1), .wrap2(wrap2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    bit           k1, k2;
    logic [7:0]   y1, y2;
    logic         v1, v2, w1, w2;
    logic [1:0]   i1, i2;
  } exp_t;

  exp_t sbq[$];
  exp_t cur_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic x1(input string nm, input logic [7:0] y, input logic v,
                    input logic [1:0] i, input logic w);
    cur_e.nm = nm; cur_e.k1 = 1'b1;
    cur_e.y1 = y; cur_e.v1 = v; cur_e.i1 = i; cur_e.w1 = w;
  endtask

  task automatic x2(input string nm, input logic [7:0] y, input logic v,
                    input logic [1:0] i, input logic w);
    cur_e.nm = nm; cur_e.k2 = 1'b1;
    cur_e.y2 = y; cur_e.v2 = v; cur_e.i2 = i; cur_e.w2 = w;
  endtask

  // One clock edge; queues whatever expectations were set for it.
  task automatic tick();
    @(posedge clk);
    #1;
    sbq.push_back(cur_e);
    cur_e.k1 = 1'b0;
    cur_e.k2 = 1'b0;
    cur_e.nm = "none";
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.k1) begin
        n_cmp++;
        if ({y1, v1, idx1, wrap1} !== {e.y1, e.v1, e.i1, e.w1}) begin
          n_bad++;
          $display("FAIL %s ch1: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                   e.nm, y1, v1, idx1, wrap1, e.y1, e.v1, e.i1, e.w1);
        end
      end
      if (e.k2) begin
        n_cmp++;
        if ({y2, v2, idx2, wrap2} !== {e.y2, e.v2, e.i2, e.w2}) begin
          n_bad++;
          $display("FAIL %s ch2: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                   e.nm, y2, v2, idx2, wrap2, e.y2, e.v2, e.i2, e.w2);
        end
      end
    end
  end

  // Expected scan sequences: y low nibble / idx and wrap per edge.
  logic [1:0] scan2_i [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  logic [1:0] d0_i    [7] = '{2, 3, 0, 1, 2, 3, 0};
  logic       d0_w    [7] = '{0, 0, 1, 0, 0, 0, 1};

  initial begin
    cur_e = '{nm: "none", k1: 0, k2: 0, y1: 0, y2: 0, v1: 0, v2: 0, w1: 0, w2: 0,
              i1: 0, i2: 0};
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < N; k++)
        din[(c*N+k)*W +: W] = 8'h10 + 8'(c*16) + 8'(k);
    rst_n = 1'b0; sel1 = 2'd3; sel2 = 2'd2; e1 = 1'b1; e2 = 1'b1; mode = 1'b1;
    dwell = 8'd2;
    tick();
    x1("reset", 8'h00, 0, 0, 0); x2("reset", 8'h00, 0, 0, 0);
    tick();

    // Direct mode, channel 2 gated off.
    rst_n = 1'b1; mode = 1'b0; sel1 = 2'd2; e2 = 1'b0; sel2 = 2'd1;
    x1("direct_sel2", 8'h12, 1, 2, 0); x2("ch2_disabled", 8'h00, 0, 0, 0);
    tick();
    sel1 = 2'd3;
    x1("direct_sel3", 8'h13, 1, 3, 0);
    tick();
    e2 = 1'b1;
    x2("ch2_enabled", 8'h21, 1, 1, 0);
    tick();
    sel1 = 2'd0;
    x1("direct_sel0", 8'h10, 1, 0, 0);
    tick();

    // Scan with dwell=2 entered at sel1=0; later select changes are ignored.
    mode = 1'b1; dwell = 8'd2; e2 = 1'b0;
    x2("ch2_off_scan", 8'h00, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      x1("scan_dwell2", 8'h10 + 8'(scan2_i[i]), 1, scan2_i[i], (i == 8));
      tick();
      sel1 = 2'd2;
    end
    x1("scan_dwell2_b", 8'h10, 1, 0, 0); tick();
    x1("scan_dwell2_c", 8'h11, 1, 1, 0); tick();

    // Pause mid-dwell at idx 1, then resume with the remaining dwell cycle.
    e1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x1("paused", 8'h00, 0, 1, 0);
      tick();
    end
    e1 = 1'b1;
    x1("resume_rest", 8'h11, 1, 1, 0); tick();
    x1("resume_next", 8'h12, 1, 2, 0); tick();

    // Dwell drops to 0 while the counter is already past the new limit.
    dwell = 8'd0;
    for (int i = 0; i < 7; i++) begin
      x1("scan_dwell0", 8'h10 + 8'(d0_i[i]), 1, d0_i[i], d0_w[i]);
      tick();
    end
    x1("scan_dwell0_b", 8'h11, 1, 1, 0); tick();
    x1("scan_dwell0_c", 8'h12, 1, 2, 0); tick();
    x1("scan_dwell0_d", 8'h13, 1, 3, 0); tick();

    // Reset for one edge at idx 3, then scan restarts at index 0 regardless of sel.
    rst_n = 1'b0; e2 = 1'b1;
    x1("rst_mid_scan", 8'h00, 0, 0, 0); x2("rst_mid_scan", 8'h00, 0, 0, 0);
    tick();
    rst_n = 1'b1; e2 = 1'b0;
    x1("post_rst_scan", 8'h10, 1, 0, 0); tick();
    x1("post_rst_scan2", 8'h11, 1, 1, 0); tick();

    // Direct -> scan entry loads the select; scan -> direct takes effect at once.
    mode = 1'b0; sel1 = 2'd2;
    x1("direct_again", 8'h12, 1, 2, 0); tick();
    mode = 1'b1; sel1 = 2'd1; dwell = 8'd3;
    for (int i = 0; i < 3; i++) begin
      x1("entry_sel1", 8'h11, 1, 1, 0);
      tick();
      sel1 = 2'd3;
    end
    x1("entry_step", 8'h12, 1, 2, 0); tick();
    mode = 1'b0; sel1 = 2'd0;
    x1("scan_to_direct", 8'h10, 1, 0, 0); tick();

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
